main_mem_ctrl: RTL

Shared memory controller between the I-cache and D-cache refill/write-through ports and main memory. It accepts block-granular requests from both caches and gives the I-cache strict priority. It serialises them into one outstanding main-memory transaction and routes the single response back to the requesting cache as a one-cycle, latency-sensitive pulse.

---
 rtl/main_mem_ctrl_pkg.sv | 30 +++
 rtl/main_mem_ctrl_skid_buf.sv | 52 +++++
 rtl/main_mem_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | main_mem_ctrl_pkg                                                          |
// | Shared types for the cache <-> main-memory controller: request type,       |
// | transaction owner and the default block/address widths.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package main_mem_ctrl_pkg;

   localparam int BLOCK_DATA_WIDTH = 64;
   localparam int ADDR_WIDTH       = 32;
   // Block address drops the byte offset within one block.
   localparam int BLK_ADDR_WIDTH   = ADDR_WIDTH - $clog2(BLOCK_DATA_WIDTH / 8);

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } req_type_t;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } mem_owner_t;

   typedef logic [BLOCK_DATA_WIDTH-1:0] block_data_t;
   typedef logic [BLK_ADDR_WIDTH-1:0]   main_mem_block_addr_t;

endpackage

`default_nettype wire

// File: rtl/main_mem_ctrl_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_skid_buf                                                           |
// | One-entry valid/address holding register. Parks an I-cache request that   |
// | arrives while the controller is busy so it can be issued once idle.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_req_skid_buf #(
   parameter int ADDR_W = 29
) (
   input  logic              clk,
   input  logic              rst_aL,
   input  logic              set_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              clr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;

   // Next entry: a set wins over a clear in the same cycle (new request overrides).
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end
      if (set_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
      end
   end

   // Entry storage, cleared by reset.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;

endmodule

`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | main_mem_ctrl                                                              |
// | Arbitrates I-cache (strict priority) and D-cache block requests onto a     |
// | single outstanding main-memory transaction and returns the response to     |
// | the requesting cache as a one-cycle pulse.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module main_mem_ctrl
   import main_mem_ctrl_pkg::*;
#(
   parameter int BLOCK_W    = BLOCK_DATA_WIDTH,
   parameter int BLK_ADDR_W = BLK_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_aL,
   // I-cache request (always READ)
   input  logic                  icache_req_valid,
   input  logic [BLK_ADDR_W-1:0] icache_req_block_addr,
   output logic                  icache_req_ready,
   // D-cache request
   input  logic                  dcache_req_valid,
   input  req_type_t             dcache_req_type,
   input  logic [BLK_ADDR_W-1:0] dcache_req_block_addr,
   input  logic [BLOCK_W-1:0]    dcache_req_block_data,
   output logic                  dcache_req_ready,
   // Cache responses
   output logic                  icache_resp_valid,
   output logic [BLOCK_W-1:0]    icache_resp_block_data,
   output logic                  dcache_resp_valid,
   output logic [BLOCK_W-1:0]    dcache_resp_block_data,
   // Main memory
   output logic                  mem_req_valid,
   output req_type_t             mem_req_type,
   output logic [BLK_ADDR_W-1:0] mem_req_block_addr,
   output logic [BLOCK_W-1:0]    mem_req_block_data,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [BLOCK_W-1:0]    mem_resp_block_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } mem_ctrl_state_t;

   mem_ctrl_state_t state_q, state_d;

   // In-flight transaction register; data doubles as the response block.
   req_type_t             txn_type_q,  txn_type_d;
   mem_owner_t            txn_owner_q, txn_owner_d;
   logic [BLK_ADDR_W-1:0] txn_addr_q,  txn_addr_d;
   logic [BLOCK_W-1:0]    txn_data_q,  txn_data_d;

   logic                  ibuf_valid;
   logic [BLK_ADDR_W-1:0] ibuf_addr;
   logic                  ibuf_set;
   logic                  ibuf_clr;

   logic                  idle;
   logic                  sel_valid;

   assign idle = (state_q == IDLE);

   // I-cache requests seen while busy are parked; in IDLE they are taken directly.
   assign ibuf_set = icache_req_valid & ~idle;

   mem_req_skid_buf #(
      .ADDR_W (BLK_ADDR_W)
   ) u_ibuf (
      .clk     (clk),
      .rst_aL  (rst_aL),
      .set_i   (ibuf_set),
      .addr_i  (icache_req_block_addr),
      .clr_i   (ibuf_clr),
      .valid_o (ibuf_valid),
      .addr_o  (ibuf_addr)
   );

   // Source selection in IDLE: parked I-cache, then live I-cache, then D-cache.
   always_comb begin
      sel_valid   = 1'b0;
      ibuf_clr    = 1'b0;
      txn_type_d  = txn_type_q;
      txn_owner_d = txn_owner_q;
      txn_addr_d  = txn_addr_q;
      txn_data_d  = txn_data_q;
      if (idle) begin
         if (ibuf_valid) begin
            sel_valid   = 1'b1;
            ibuf_clr    = 1'b1;
            txn_type_d  = READ;
            txn_owner_d = ICACHE;
            txn_addr_d  = ibuf_addr;
            txn_data_d  = '0;
         end else if (icache_req_valid) begin
            sel_valid   = 1'b1;
            txn_type_d  = READ;
            txn_owner_d = ICACHE;
            txn_addr_d  = icache_req_block_addr;
            txn_data_d  = '0;
         end else if (dcache_req_valid) begin
            sel_valid   = 1'b1;
            txn_type_d  = dcache_req_type;
            txn_owner_d = DCACHE;
            txn_addr_d  = dcache_req_block_addr;
            txn_data_d  = dcache_req_block_data;
         end
      end else if ((state_q == WAIT) && mem_resp_valid && (txn_type_q == READ)) begin
         // WRITE keeps its own block as the response so the cache rewrites identical data.
         txn_data_d = mem_resp_block_data;
      end
   end

   // Transaction register storage.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         txn_type_q  <= READ;
         txn_owner_q <= ICACHE;
         txn_addr_q  <= '0;
         txn_data_q  <= '0;
      end else begin
         txn_type_q  <= txn_type_d;
         txn_owner_q <= txn_owner_d;
         txn_addr_q  <= txn_addr_d;
         txn_data_q  <= txn_data_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; responses outside WAIT are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_valid)      state_d = REQ;
         REQ:     if (mem_req_ready)  state_d = WAIT;
         WAIT:    if (mem_resp_valid) state_d = RESP;
         RESP:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // FSM outputs; data buses read zero whenever their valid is low.
   always_comb begin
      icache_req_ready       = 1'b1;
      dcache_req_ready       = idle & ~ibuf_valid & ~icache_req_valid;
      mem_req_valid          = 1'b0;
      mem_req_type           = READ;
      mem_req_block_addr     = '0;
      mem_req_block_data     = '0;
      icache_resp_valid      = 1'b0;
      icache_resp_block_data = '0;
      dcache_resp_valid      = 1'b0;
      dcache_resp_block_data = '0;
      if (state_q == REQ) begin
         mem_req_valid      = 1'b1;
         mem_req_type       = txn_type_q;
         mem_req_block_addr = txn_addr_q;
         mem_req_block_data = txn_data_q;
      end
      if (state_q == RESP) begin
         if (txn_owner_q == ICACHE) begin
            icache_resp_valid      = 1'b1;
            icache_resp_block_data = txn_data_q;
         end else begin
            dcache_resp_valid      = 1'b1;
            dcache_resp_block_data = txn_data_q;
         end
      end
   end

   // The I-cache never issues while awaiting its response, so the buffer cannot overflow.
   a_ibuf_no_overflow : assert property (@(posedge clk) disable iff (!rst_aL)
      !(icache_req_valid && ibuf_valid));

   // A stray completion (e.g. left over from before a reset) is ignored; flag it only.
   a_resp_only_in_wait : assert property (@(posedge clk) disable iff (!rst_aL)
      !(mem_resp_valid && (state_q != WAIT)))
      else $warning("main_mem_ctrl: mem_resp_valid outside WAIT ignored");

endmodule

`default_nettype wire
